// File: rtl/fc_pkg.sv
// Shared types and constants for the FC accumulate/bias/argmax stage.
// Build option FC_RELU_CLIP_EN enables the quantised ReLU/clip output.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } fc_state_e;

    localparam int PSUM_W_DEF = 22;
    localparam int BIAS_W_DEF = 16;
    localparam int ACC_W_DEF  = 26;

    // neuron_q takes neuron_out scaled down by 2^Q_SHIFT, clipped to Q_CLIP
    localparam int Q_SHIFT = 10;
    localparam int Q_CLIP  = 127;
    localparam int Q_W     = 8;

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running signed maximum over neuron results; ties keep the earliest index.
module fc_argmax_tracker
    import fc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic [ACC_W-1:0] value,
    input  logic [IDX_W-1:0] index,
    output logic [ACC_W-1:0] best_val,
    output logic [IDX_W-1:0] best_idx
);

    logic             have_q, have_d;
    logic [ACC_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    always_comb begin
        have_d     = have_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (clear) begin
            have_d     = 1'b0;
            best_val_d = '0;
            best_idx_d = '0;
        end else if (update && (!have_q || ($signed(value) > $signed(best_val_q)))) begin
            have_d     = 1'b1;
            best_val_d = value;
            best_idx_d = index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_q     <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            have_q     <= have_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_val = best_val_q;
    assign best_idx = best_idx_q;

endmodule

// File: rtl/fc_accum_argmax.sv
// Accumulates per-neuron partial sums, adds ROM bias, emits results and the argmax class.
// Build option FC_RELU_CLIP_EN registers a quantised ReLU/clip value on neuron_q.
module fc_accum_argmax
    import fc_pkg::*;
#(
    parameter int CHUNKS_PER_NEURON = 4,
    parameter int NUM_NEURONS       = 10,
    parameter int PSUM_W            = PSUM_W_DEF,
    parameter int BIAS_W            = BIAS_W_DEF,
    parameter int ACC_W             = ACC_W_DEF,
    parameter int IDX_W             = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum,
    output logic [IDX_W-1:0]  bias_rd_addr,
    input  logic [BIAS_W-1:0] bias_rd_data,
    output logic              busy,
    output logic              neuron_valid,
    output logic [IDX_W-1:0]  neuron_idx,
    output logic [ACC_W-1:0]  neuron_out,
    output logic [7:0]        neuron_q,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [ACC_W-1:0]  class_score,
    output logic              err_stray
);

    localparam int CHUNK_W = (CHUNKS_PER_NEURON > 1) ? $clog2(CHUNKS_PER_NEURON) : 1;

    if ((CHUNKS_PER_NEURON < 2) || (ACC_W < PSUM_W + $clog2(CHUNKS_PER_NEURON) + 1) ||
        (IDX_W < $clog2(NUM_NEURONS))) begin : g_param_check
        $error("fc_accum_argmax: parameter constraint violated");
    end

    fc_state_e        state_q, state_d;
    logic [IDX_W-1:0] neuron_cnt_q, neuron_cnt_d;
    logic [CHUNK_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             err_q, err_d;
    logic             nv_q, nv_d;
    logic [IDX_W-1:0] nidx_q, nidx_d;
    logic [ACC_W-1:0] nout_q, nout_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] cls_idx_q, cls_idx_d;
    logic [ACC_W-1:0] cls_score_q, cls_score_d;
    logic             trk_clear, trk_update;
    logic [ACC_W-1:0] best_val;
    logic [IDX_W-1:0] best_idx;
    logic [ACC_W-1:0] psum_ext, bias_ext, result;

    assign psum_ext = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
    assign bias_ext = {{(ACC_W-BIAS_W){bias_rd_data[BIAS_W-1]}}, bias_rd_data};
    assign result   = acc_q + bias_ext;

    always_comb begin
        state_d      = state_q;
        neuron_cnt_d = neuron_cnt_q;
        chunk_cnt_d  = chunk_cnt_q;
        acc_d        = acc_q;
        err_d        = err_q;
        nv_d         = 1'b0;
        nidx_d       = nidx_q;
        nout_d       = nout_q;
        done_d       = 1'b0;
        cls_idx_d    = cls_idx_q;
        cls_score_d  = cls_score_q;
        trk_clear    = 1'b0;
        trk_update   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psum_valid) err_d = 1'b1;
                if (start) begin
                    state_d      = ACCUM;
                    neuron_cnt_d = '0;
                    chunk_cnt_d  = '0;
                    acc_d        = '0;
                    trk_clear    = 1'b1;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    acc_d = acc_q + psum_ext;
                    if (chunk_cnt_q == CHUNK_W'(CHUNKS_PER_NEURON - 1)) begin
                        chunk_cnt_d = '0;
                        state_d     = BIAS;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
                    end
                end
            end
            BIAS: begin
                nout_d      = result;
                nidx_d      = neuron_cnt_q;
                nv_d        = 1'b1;
                trk_update  = 1'b1;
                acc_d       = '0;
                chunk_cnt_d = '0;
                if (neuron_cnt_q == IDX_W'(NUM_NEURONS - 1)) begin
                    state_d = DONE;
                    if (psum_valid) err_d = 1'b1;
                end else begin
                    state_d      = ACCUM;
                    neuron_cnt_d = neuron_cnt_q + IDX_W'(1);
                    // A strobe here already belongs to the next neuron
                    if (psum_valid) begin
                        acc_d       = psum_ext;
                        chunk_cnt_d = CHUNK_W'(1);
                    end
                end
            end
            DONE: begin
                if (psum_valid) err_d = 1'b1;
                done_d      = 1'b1;
                cls_idx_d   = best_idx;
                cls_score_d = best_val;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            neuron_cnt_q <= '0;
            chunk_cnt_q  <= '0;
            acc_q        <= '0;
            err_q        <= 1'b0;
            nv_q         <= 1'b0;
            nidx_q       <= '0;
            nout_q       <= '0;
            done_q       <= 1'b0;
            cls_idx_q    <= '0;
            cls_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            neuron_cnt_q <= neuron_cnt_d;
            chunk_cnt_q  <= chunk_cnt_d;
            acc_q        <= acc_d;
            err_q        <= err_d;
            nv_q         <= nv_d;
            nidx_q       <= nidx_d;
            nout_q       <= nout_d;
            done_q       <= done_d;
            cls_idx_q    <= cls_idx_d;
            cls_score_q  <= cls_score_d;
        end
    end

    fc_argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (trk_clear),
        .update   (trk_update),
        .value    (result),
        .index    (neuron_cnt_q),
        .best_val (best_val),
        .best_idx (best_idx)
    );

`ifdef FC_RELU_CLIP_EN
    localparam int QH_W = ACC_W - 1 - Q_SHIFT;
    logic [Q_W-1:0] nq_q, nq_d, clip_val;

    always_comb begin
        if (result[ACC_W-1]) begin
            clip_val = '0;
        end else if (result[ACC_W-2:Q_SHIFT] > QH_W'(Q_CLIP)) begin
            clip_val = Q_W'(Q_CLIP);
        end else begin
            clip_val = result[Q_SHIFT+Q_W-1:Q_SHIFT];
        end
        nq_d = nv_d ? clip_val : nq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) nq_q <= '0;
        else     nq_q <= nq_d;
    end

    assign neuron_q = nq_q;
`else
    assign neuron_q = 8'd0;
`endif

    assign bias_rd_addr = neuron_cnt_q;
    assign busy         = (state_q != IDLE);
    assign neuron_valid = nv_q;
    assign neuron_idx   = nidx_q;
    assign neuron_out   = nout_q;
    assign done         = done_q;
    assign class_idx    = cls_idx_q;
    assign class_score  = cls_score_q;
    assign err_stray    = err_q;

endmodule

// File: tb/tb_fc_accum_argmax.sv
// Directed bench for fc_accum_argmax: arithmetic reference model, scoreboard, literal pins.
// Define FC_RELU_CLIP_EN to check the quantised output path.
module tb_fc_accum_argmax;

    localparam int NN     = 10;
    localparam int CH     = 4;
    localparam int PSUM_W = 22;
    localparam int BIAS_W = 16;
    localparam int ACC_W  = 26;
    localparam int IDX_W  = 4;
    localparam int EW     = IDX_W + ACC_W + 8;
    localparam int CW     = IDX_W + ACC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              psum_valid = 1'b0;
    logic [PSUM_W-1:0] psum = '0;
    logic [IDX_W-1:0]  bias_rd_addr;
    logic [BIAS_W-1:0] bias_rd_data = '0;
    logic              busy, neuron_valid, done, err_stray;
    logic [IDX_W-1:0]  neuron_idx, class_idx;
    logic [ACC_W-1:0]  neuron_out, class_score;
    logic [7:0]        neuron_q;

    fc_accum_argmax dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .psum_valid   (psum_valid),
        .psum         (psum),
        .bias_rd_addr (bias_rd_addr),
        .bias_rd_data (bias_rd_data),
        .busy         (busy),
        .neuron_valid (neuron_valid),
        .neuron_idx   (neuron_idx),
        .neuron_out   (neuron_out),
        .neuron_q     (neuron_q),
        .done         (done),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .err_stray    (err_stray)
    );

    // ---------------- clock / reset / bias ROM ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BIAS_W-1:0] bias_rom [0:15];
    always @(posedge clk) bias_rd_data <= bias_rom[bias_rd_addr];

    int psum_tab [0:NN-1][0:CH-1];

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [CW-1:0] exp_cls_q[$];
    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int last_strobe_cyc = 0;
    int got_out [0:15];
    int got_q [0:15];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_q(input int v);
`ifdef FC_RELU_CLIP_EN
        if (v < 0) return 8'd0;
        if (v / 1024 > 127) return 8'd127;
        return 8'(v / 1024);
`else
        return 8'(v & 0);
`endif
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (neuron_valid) begin
                got_out[neuron_idx] = int'($signed(neuron_out));
                got_q[neuron_idx]   = int'(neuron_q);
                if (exp_q.size() == 0) begin
                    chk("unexpected_neuron_valid", 64'(neuron_idx), 64'hFFFF);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("neuron_idx", 64'(neuron_idx), 64'(e[EW-1 -: IDX_W]));
                    chk("neuron_out", 64'(neuron_out), 64'(e[ACC_W+7:8]));
                    chk("neuron_q", 64'(neuron_q), 64'(e[7:0]));
                end
            end
            if (done) begin
                done_count++;
                if (exp_cls_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    logic [CW-1:0] c;
                    c = exp_cls_q.pop_front();
                    chk("class_idx", 64'(class_idx), 64'(c[CW-1 -: IDX_W]));
                    chk("class_score", 64'(class_score), 64'(c[ACC_W-1:0]));
                    chk("done_latency", 64'(cyc), 64'(last_strobe_cyc + 3));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model computes sums from the tables, then the stimulus is played out.
    // abort_at >= 0 stops after two chunks of that neuron and returns busy.
    task automatic run_inf(input int gap, input int abort_at);
        int sum, best_v, best_i, n_end;
        logic [CW-1:0] ce;
        n_end = (abort_at < 0) ? NN : abort_at;
        best_v = 0;
        best_i = 0;
        for (int i = 0; i < NN; i++) begin
            sum = int'($signed(bias_rom[i]));
            for (int c = 0; c < CH; c++) sum += psum_tab[i][c];
            if (i < n_end) exp_q.push_back({IDX_W'(i), ACC_W'(sum), model_q(sum)});
            if (i == 0 || sum > best_v) begin
                best_v = sum;
                best_i = i;
            end
        end
        if (abort_at < 0) begin
            ce = {IDX_W'(best_i), ACC_W'(best_v)};
            exp_cls_q.push_back(ce);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NN; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (i == abort_at && c == 2) return;
                psum_valid      = 1'b1;
                psum            = PSUM_W'(psum_tab[i][c]);
                last_strobe_cyc = cyc;
                tick();
                psum_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        begin
            int d0;
            d0 = done_count;
            for (int k = 0; k < 20 && done_count == d0; k++) tick();
            chk("done_seen", 64'(done_count), 64'(d0 + 1));
        end
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_neuron_valid"}, 64'(neuron_valid), 64'd0);
        chk({tag, "_neuron_idx"}, 64'(neuron_idx), 64'd0);
        chk({tag, "_neuron_out"}, 64'(neuron_out), 64'd0);
        chk({tag, "_neuron_q"}, 64'(neuron_q), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_class_idx"}, 64'(class_idx), 64'd0);
        chk({tag, "_class_score"}, 64'(class_score), 64'd0);
        chk({tag, "_err_stray"}, 64'(err_stray), 64'd0);
        chk({tag, "_bias_rd_addr"}, 64'(bias_rd_addr), 64'd0);
    endtask

    task automatic load_uniform(input int base_mul, input int bias_all);
        for (int i = 0; i < NN; i++) begin
            bias_rom[i] = BIAS_W'(bias_all);
            for (int c = 0; c < CH; c++) psum_tab[i][c] = base_mul * (i + 1);
        end
    endtask

    task automatic load_tie();
        for (int i = 0; i < NN; i++) begin
            bias_rom[i] = '0;
            for (int c = 0; c < CH; c++) psum_tab[i][c] = (i == 3 || i == 7) ? 1250 : 25;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) bias_rom[i] = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Scenario 1: ramp values, gaps between strobes
        load_uniform(100, 0);
        run_inf(2, -1);
        chk("s1_class_idx_lit", 64'(class_idx), 64'd9);
        chk("s1_class_score_lit", 64'(class_score), 64'd4000);
        chk("s1_neuron0_lit", 64'(got_out[0]), 64'd400);
        chk("s1_neuron9_lit", 64'(got_out[9]), 64'd4000);

        // Scenario 2: most negative psums and bias, no wrap
        for (int i = 0; i < NN; i++) begin
            bias_rom[i] = '0;
            for (int c = 0; c < CH; c++) psum_tab[i][c] = -2097152;
        end
        bias_rom[0] = BIAS_W'(-32768);
        run_inf(1, -1);
        chk("s2_neuron0_lit", 64'(got_out[0]), 64'(-8421376));
        chk("s2_class_idx_lit", 64'(class_idx), 64'd1);

        // Scenario 3: tie between neurons 3 and 7
        load_tie();
        run_inf(1, -1);
        chk("s3_class_idx_lit", 64'(class_idx), 64'd3);
        chk("s3_class_score_lit", 64'(class_score), 64'd5000);

        // Scenario 4: back-to-back strobes, one carried through each BIAS cycle
        for (int i = 0; i < NN; i++) begin
            bias_rom[i] = BIAS_W'(2);
            for (int c = 0; c < CH; c++) psum_tab[i][c] = 1;
        end
        for (int i = 0; i < NN; i++) got_out[i] = 0;
        run_inf(0, -1);
        chk("s4_neuron5_lit", 64'(got_out[5]), 64'd6);
        chk("s4_err_stray", 64'(err_stray), 64'd0);

        // Scenario 5: reset during neuron 5, then a fresh inference
        load_uniform(100, 0);
        run_inf(2, 5);
        rst = 1'b1;
        @(posedge clk);
        check_outputs_zero("midrst");
        tick();
        rst = 1'b0;
        begin
            int d0;
            d0 = done_count;
            repeat (12) tick();
            chk("midrst_no_done", 64'(done_count), 64'(d0));
        end
        chk("midrst_scoreboard", 64'(exp_q.size()), 64'd0);
        run_inf(2, -1);
        chk("s5_class_idx_lit", 64'(class_idx), 64'd9);
        chk("s5_class_score_lit", 64'(class_score), 64'd4000);

        // Stray strobe in IDLE is flagged and dropped
        psum_valid = 1'b1;
        psum       = PSUM_W'(12345);
        tick();
        psum_valid = 1'b0;
        @(negedge clk);
        chk("stray_err_set", 64'(err_stray), 64'd1);
        chk("stray_not_busy", 64'(busy), 64'd0);
        tick();
        load_tie();
        run_inf(1, -1);
        chk("stray_class_idx_lit", 64'(class_idx), 64'd3);
        chk("stray_class_score_lit", 64'(class_score), 64'd5000);
        chk("stray_err_sticky", 64'(err_stray), 64'd1);

        // Scenario 6: quantisation points 5120, 200000, -5
        for (int i = 0; i < NN; i++) begin
            bias_rom[i] = '0;
            for (int c = 0; c < CH; c++) psum_tab[i][c] = 0;
        end
        for (int c = 0; c < CH; c++) begin
            psum_tab[0][c] = 1280;
            psum_tab[1][c] = 50000;
        end
        bias_rom[2] = BIAS_W'(-5);
        run_inf(1, -1);
        chk("s6_out1_lit", 64'(got_out[1]), 64'd200000);
        chk("s6_class_idx_lit", 64'(class_idx), 64'd1);
`ifdef FC_RELU_CLIP_EN
        chk("s6_q0_lit", 64'(got_q[0]), 64'd5);
        chk("s6_q1_lit", 64'(got_q[1]), 64'd127);
        chk("s6_q2_lit", 64'(got_q[2]), 64'd0);
`else
        chk("s6_q0_lit", 64'(got_q[0]), 64'd0);
        chk("s6_q1_lit", 64'(got_q[1]), 64'd0);
        chk("s6_q2_lit", 64'(got_q[2]), 64'd0);
`endif

        repeat (3) tick();
        chk("final_scoreboard", 64'(exp_q.size() + exp_cls_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
